// File: rtl/axi_lite_ram_if.sv
// AXI4-Lite bus bundle between a core master port and the RAM slave.
// Signal names match the flat AXI4-Lite port list of the RAM.
interface axi_lite_ram_if;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
               axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
               axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave RAM with byte strobes, configurable read latency and SLVERR
// on out-of-range accesses. Write and read channels run independent FSMs.
module axi_lite_ram #(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    axi_lite_ram_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;
    localparam logic [1:0]  OKAY  = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic {W_COLLECT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_VALID} r_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic in_range(input logic [31:0] addr);
        return {1'b0, addr - BASE_ADDR} < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state, w_state_n;
    logic        aw_held, aw_held_n, w_held, w_held_n;
    logic [31:0] awaddr_q, awaddr_n, wdata_q, wdata_n;
    logic [3:0]  wstrb_q, wstrb_n;
    logic        awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
    logic [1:0]  bresp_q, bresp_n;
    logic        commit;

    always_comb begin
        w_state_n = w_state;
        aw_held_n = aw_held;
        w_held_n  = w_held;
        awaddr_n  = awaddr_q;
        wdata_n   = wdata_q;
        wstrb_n   = wstrb_q;
        awready_n = awready_q;
        wready_n  = wready_q;
        bvalid_n  = bvalid_q;
        bresp_n   = bresp_q;
        commit    = 1'b0;
        unique case (w_state)
            W_COLLECT: begin
                if (bus.axi_awvalid && awready_q) begin
                    aw_held_n = 1'b1;
                    awaddr_n  = bus.axi_awaddr;
                end
                if (bus.axi_wvalid && wready_q) begin
                    w_held_n = 1'b1;
                    wdata_n  = bus.axi_wdata;
                    wstrb_n  = bus.axi_wstrb;
                end
                // Commit on the edge that completes the second handshake.
                if (aw_held_n && w_held_n) begin
                    commit    = 1'b1;
                    w_state_n = W_RESP;
                    bvalid_n  = 1'b1;
                    bresp_n   = in_range(awaddr_n) ? OKAY : SLVERR;
                    awready_n = 1'b0;
                    wready_n  = 1'b0;
                end else begin
                    awready_n = !aw_held_n;
                    wready_n  = !w_held_n;
                end
            end
            W_RESP: begin
                if (bus.axi_bready) begin
                    w_state_n = W_COLLECT;
                    aw_held_n = 1'b0;
                    w_held_n  = 1'b0;
                    bvalid_n  = 1'b0;
                    awready_n = 1'b1;
                    wready_n  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            w_state   <= w_state_n;
            aw_held   <= aw_held_n;
            w_held    <= w_held_n;
            awaddr_q  <= awaddr_n;
            wdata_q   <= wdata_n;
            wstrb_q   <= wstrb_n;
            awready_q <= awready_n;
            wready_q  <= wready_n;
            bvalid_q  <= bvalid_n;
            bresp_q   <= bresp_n;
        end
    end

    // Array is never reset; a read sampling on the commit edge sees old data.
    always_ff @(posedge clk) begin
        if (rst_n && commit && in_range(awaddr_n)) begin
            for (int b = 0; b < 4; b++)
                if (wstrb_n[b]) mem[word_idx(awaddr_n)][8*b +: 8] <= wdata_n[8*b +: 8];
        end
    end

    // ---------------- read channel ----------------
    r_state_t    r_state, r_state_n;
    logic [3:0]  cnt_q, cnt_n;
    logic [31:0] araddr_q, araddr_n, rdata_q, rdata_n, rd_addr, rd_word;
    logic [1:0]  rresp_q, rresp_n;
    logic        arready_q, arready_n, rvalid_q, rvalid_n, rd_ok;

    always_comb begin
        r_state_n = r_state;
        cnt_n     = cnt_q;
        araddr_n  = araddr_q;
        rdata_n   = rdata_q;
        rresp_n   = rresp_q;
        arready_n = arready_q;
        rvalid_n  = rvalid_q;
        rd_addr   = (r_state == R_IDLE) ? bus.axi_araddr : araddr_q;
        rd_ok     = in_range(rd_addr);
        rd_word   = rd_ok ? mem[word_idx(rd_addr)] : 32'h0;
        unique case (r_state)
            R_IDLE: begin
                arready_n = 1'b1;
                if (bus.axi_arvalid && arready_q) begin
                    araddr_n  = bus.axi_araddr;
                    arready_n = 1'b0;
                    if (READ_LATENCY == 1) begin
                        r_state_n = R_VALID;
                        rvalid_n  = 1'b1;
                        rdata_n   = rd_word;
                        rresp_n   = rd_ok ? OKAY : SLVERR;
                    end else begin
                        r_state_n = R_WAIT;
                        cnt_n     = 4'(READ_LATENCY - 1);
                    end
                end
            end
            R_WAIT: begin
                cnt_n = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    r_state_n = R_VALID;
                    rvalid_n  = 1'b1;
                    rdata_n   = rd_word;
                    rresp_n   = rd_ok ? OKAY : SLVERR;
                end
            end
            R_VALID: begin
                if (bus.axi_rready) begin
                    r_state_n = R_IDLE;
                    rvalid_n  = 1'b0;
                    arready_n = 1'b1;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= R_IDLE;
            cnt_q     <= '0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            r_state   <= r_state_n;
            cnt_q     <= cnt_n;
            araddr_q  <= araddr_n;
            rdata_q   <= rdata_n;
            rresp_q   <= rresp_n;
            arready_q <= arready_n;
            rvalid_q  <= rvalid_n;
        end
    end

    assign bus.axi_awready = awready_q;
    assign bus.axi_wready  = wready_q;
    assign bus.axi_bvalid  = bvalid_q;
    assign bus.axi_bresp   = bresp_q;
    assign bus.axi_arready = arready_q;
    assign bus.axi_rvalid  = rvalid_q;
    assign bus.axi_rdata   = rdata_q;
    assign bus.axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_ram.sv
// Bench for axi_lite_ram: two instances (read latency 1 and 4) share write
// stimulus; reads target one of them. Checked against an array model.
module tb_axi_lite_ram;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] SPAN  = DEPTH * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_lite_ram_if b1 ();
    axi_lite_ram_if b4 ();

    axi_lite_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(1))
        u_ram1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    axi_lite_ram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(4))
        u_ram4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb  = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic arvalid = 1'b0, rready = 1'b0, sel = 1'b0;

    assign b1.axi_awaddr  = awaddr;   assign b4.axi_awaddr  = awaddr;
    assign b1.axi_awvalid = awvalid;  assign b4.axi_awvalid = awvalid;
    assign b1.axi_wdata   = wdata;    assign b4.axi_wdata   = wdata;
    assign b1.axi_wstrb   = wstrb;    assign b4.axi_wstrb   = wstrb;
    assign b1.axi_wvalid  = wvalid;   assign b4.axi_wvalid  = wvalid;
    assign b1.axi_bready  = bready;   assign b4.axi_bready  = bready;
    assign b1.axi_araddr  = araddr;   assign b4.axi_araddr  = araddr;
    assign b1.axi_rready  = rready;   assign b4.axi_rready  = rready;
    assign b1.axi_arvalid = arvalid && !sel;
    assign b4.axi_arvalid = arvalid && sel;

    logic [31:0] ref_mem [DEPTH];
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off < SPAN;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic ar_rdy(input bit s4);
        return s4 ? b4.axi_arready : b1.axi_arready;
    endfunction
    function automatic logic rv(input bit s4);
        return s4 ? b4.axi_rvalid : b1.axi_rvalid;
    endfunction
    function automatic logic [31:0] rd(input bit s4);
        return s4 ? b4.axi_rdata : b1.axi_rdata;
    endfunction
    function automatic logic [1:0] rr(input bit s4);
        return s4 ? b4.axi_rresp : b1.axi_rresp;
    endfunction

    // skew = how many cycles AW is presented after W (negative: AW leads).
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int skew, input int bdly);
        bit aw_done, w_done, aw_on, w_on, hs_aw, hs_w;
        int cyc;
        logic [1:0] exp_resp;
        aw_done = 0; w_done = 0; cyc = 0;
        exp_resp = in_rng(a) ? 2'b00 : 2'b10;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            aw_on = !aw_done && (cyc >= skew);
            w_on  = !w_done && (cyc >= -skew);
            awvalid = aw_on;
            wvalid  = w_on;
            chk("bvalid_early", b1.axi_bvalid, 0);
            if (w_done)  chk("wready_after_w", b1.axi_wready, 0);
            if (aw_done) chk("awready_after_aw", b1.axi_awready, 0);
            hs_aw = aw_on && b1.axi_awready;
            hs_w  = w_on && b1.axi_wready;
            @(negedge clk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
            cyc++;
        end
        awvalid = 0;
        wvalid  = 0;
        if (!(aw_done && w_done)) begin
            chk("aw_w_timeout", 0, 1);
            return;
        end
        chk("bvalid_rise", b1.axi_bvalid, 1);
        chk("bvalid_rise4", b4.axi_bvalid, 1);
        chk("ready_in_resp", {b1.axi_awready, b1.axi_wready}, 0);
        repeat (bdly) begin
            chk("bvalid_hold", b1.axi_bvalid, 1);
            chk("bresp_hold", b1.axi_bresp, exp_resp);
            @(negedge clk);
        end
        chk("bresp", b1.axi_bresp, exp_resp);
        chk("bresp4", b4.axi_bresp, exp_resp);
        bready = 1;
        @(negedge clk);
        bready = 0;
        chk("bvalid_clr", b1.axi_bvalid, 0);
        chk("ready_back", {b1.axi_awready, b1.axi_wready}, 2'b11);
        if (in_rng(a))
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_read(input logic [31:0] a, input bit s4, input int rdly,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
        int cyc, lat;
        cyc = 0; lat = 1;
        sel = s4; araddr = a; arvalid = 1;
        while (!ar_rdy(s4) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!ar_rdy(s4)) begin
            chk("ar_timeout", 0, 1);
            arvalid = 0;
            return;
        end
        @(negedge clk);
        arvalid = 0;
        while (!rv(s4) && lat < 40) begin
            chk("arready_busy", ar_rdy(s4), 0);
            @(negedge clk);
            lat++;
        end
        chk("rd_latency", lat, s4 ? 4 : 1);
        repeat (rdly) begin
            chk("rvalid_hold", rv(s4), 1);
            chk("rdata_hold", rd(s4), exp_d);
            chk("rresp_hold", rr(s4), exp_r);
            chk("arready_hold", ar_rdy(s4), 0);
            @(negedge clk);
        end
        chk("rdata", rd(s4), exp_d);
        chk("rresp", rr(s4), exp_r);
        rready = 1;
        @(negedge clk);
        rready = 0;
        chk("rvalid_clr", rv(s4), 0);
        chk("arready_back", ar_rdy(s4), 1);
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_rdy1"}, {b1.axi_awready, b1.axi_wready, b1.axi_arready}, 0);
        chk({tag, "_rdy4"}, {b4.axi_awready, b4.axi_wready, b4.axi_arready}, 0);
        chk({tag, "_vld"}, {b1.axi_bvalid, b1.axi_rvalid, b4.axi_bvalid, b4.axi_rvalid}, 0);
        chk({tag, "_resp"}, {b1.axi_bresp, b1.axi_rresp, b4.axi_bresp, b4.axi_rresp}, 0);
        chk({tag, "_rdata1"}, b1.axi_rdata, 0);
        chk({tag, "_rdata4"}, b4.axi_rdata, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, old;
        repeat (3) @(negedge clk);
        chk_all_reset("reset");
        rst_n = 1;
        #1 chk("rdy_before_edge", {b1.axi_awready, b1.axi_wready, b1.axi_arready}, 0);
        @(posedge clk);
        #1 chk("rdy_first_edge", {b1.axi_awready, b1.axi_wready, b1.axi_arready,
                                  b4.axi_arready}, 4'hF);
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) axi_write(BASE + i * 4, $urandom, 4'hF, 0, 0);

        // basic write / read
        axi_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_read(BASE + 32'h10, 0, 0, 32'hDEAD_BEEF, 2'b00);

        // byte strobes and empty strobe
        axi_write(BASE + 32'h20, 32'h1122_3344, 4'hF, 0, 1);
        axi_write(BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0);
        axi_read(BASE + 32'h20, 0, 0, 32'h11BB_33DD, 2'b00);
        axi_write(BASE + 32'h20, 32'h5555_5555, 4'h0, 0, 0);
        axi_read(BASE + 32'h20, 1, 1, 32'h11BB_33DD, 2'b00);

        // channel ordering
        axi_write(BASE + 32'h24, 32'hA5A5_0001, 4'hF, 3, 0);
        axi_read(BASE + 32'h24, 0, 0, 32'hA5A5_0001, 2'b00);
        axi_write(BASE + 32'h28, 32'hA5A5_0002, 4'hF, -3, 0);
        axi_read(BASE + 32'h28, 1, 0, 32'hA5A5_0002, 2'b00);
        axi_write(BASE + 32'h2C, 32'hA5A5_0003, 4'hF, 0, 0);
        axi_read(BASE + 32'h2F, 0, 0, 32'hA5A5_0003, 2'b00);

        // out of range, under backpressure, plus range edges
        axi_read(BASE + SPAN, 0, 5, 32'h0, 2'b10);
        axi_read(BASE + SPAN, 1, 5, 32'h0, 2'b10);
        axi_read(BASE - 4, 0, 0, 32'h0, 2'b10);
        axi_write(BASE + SPAN, 32'hFFFF_FFFF, 4'hF, 1, 2);
        axi_read(BASE, 0, 0, ref_mem[0], 2'b00);
        axi_write(BASE + SPAN - 4, 32'hCAFE_0F0F, 4'hF, 0, 0);
        axi_read(BASE + SPAN - 1, 1, 0, 32'hCAFE_0F0F, 2'b00);

        // collision: write commits on the edge that samples rdata (latency 4)
        old = ref_mem[5];
        fork
            axi_read(BASE + 32'h14, 1, 2, old, 2'b00);
            begin
                repeat (3) @(negedge clk);
                axi_write(BASE + 32'h14, ~old, 4'hF, 0, 0);
            end
        join
        axi_read(BASE + 32'h14, 1, 0, ~old, 2'b00);

        // randomized traffic against the array model
        for (int it = 0; it < 80; it++) begin
            a = BASE + $urandom_range(0, DEPTH + 2) * 4 + $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = BASE - 4 * $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)));
            else
                axi_read(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                         in_rng(a) ? ref_mem[widx(a)] : 32'h0, in_rng(a) ? 2'b00 : 2'b10);
        end

        // reset during R_WAIT, with a lone W already held on the write side
        axi_read(BASE + 32'h10, 1, 0, ref_mem[4], 2'b00);
        sel = 1; araddr = BASE + 32'h8; arvalid = 1;
        wdata = 32'h0BAD_0BAD; wstrb = 4'hF; wvalid = 1;
        @(negedge clk);
        arvalid = 0; wvalid = 0;
        chk("in_wait", b4.axi_rvalid, 0);
        #2 rst_n = 0;
        #1 chk_all_reset("async_rst");
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1 chk("arready_after_rst", {b4.axi_arready, b1.axi_awready, b1.axi_wready}, 3'b111);
        repeat (6) @(negedge clk);
        chk("no_rvalid_after_rst", b4.axi_rvalid, 0);
        axi_write(BASE + 32'h30, 32'h0123_4567, 4'hF, -3, 0);
        axi_read(BASE + 32'h30, 0, 0, 32'h0123_4567, 2'b00);
        axi_read(BASE + 32'h30, 1, 0, 32'h0123_4567, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
